// File: rtl/cia_if.sv
// cia_if: request/strobe bundle between address decode, the CIA sequencer and the CIA pins.
interface cia_if;
  logic       cia_space_i;
  logic       rnw_i;
  logic [1:0] a_i;
  logic       clkcia_i;
  logic       nciacs0_o;
  logic       nciacs1_o;
  logic       nciabufen_o;
  logic       cia_dlatch_o;
  logic       cia_done_o;
  logic       cia_tea_o;
  logic       cia_busy_o;
  modport slave (
    input  cia_space_i, rnw_i, a_i, clkcia_i,
    output nciacs0_o, nciacs1_o, nciabufen_o, cia_dlatch_o, cia_done_o, cia_tea_o, cia_busy_o
  );
  modport master (
    output cia_space_i, rnw_i, a_i, clkcia_i,
    input  nciacs0_o, nciacs1_o, nciabufen_o, cia_dlatch_o, cia_done_o, cia_tea_o, cia_busy_o
  );
endinterface

// File: rtl/cia_cycle_sequencer.sv
// cia_cycle_sequencer: aligns 68040 CIA accesses to synchronized E-clock phases.
// Optional E-wait watchdog enabled by defining CIA_TIMEOUT_EN.
module cia_cycle_sequencer #(
  parameter int E_SYNC_STAGES = 2,
  parameter int TIMEOUT_CLKS  = 128
) (
  input logic  clk,
  input logic  rst,
  cia_if.slave bus
);
  typedef enum logic [2:0] {IDLE, SYNC, SETUP, STROBE, HOLD} state_t;
  state_t                   state_q, state_d;
  logic [E_SYNC_STAGES-1:0] sync_q;
  logic                     e_d_q, e_s, e_fall, e_rise;
  logic                     armed_q, armed_d, rnw_q, rnw_d, accept, sel, to_hit;
  logic [1:0]               a_q, a_d;
  logic                     cs0_q, cs1_q, buf_q, dl_q, done_q, tea_q, busy_q;
  logic                     cs0_d, cs1_d, buf_d, dl_d, done_d, tea_d, busy_d;
  assign e_s    = sync_q[E_SYNC_STAGES-1];
  assign e_fall = e_d_q & ~e_s;
  assign e_rise = ~e_d_q & e_s;
  assign accept = (state_q == IDLE) & bus.cia_space_i & armed_q;
`ifdef CIA_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CLKS + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          waiting;
  assign waiting = (state_q == SYNC) | (state_q == SETUP) | (state_q == STROBE);
  assign to_hit  = waiting & (cnt_q == CW'(TIMEOUT_CLKS - 1));
  always_comb cnt_d = (state_d != state_q) ? '0 : waiting ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
`else
  // no watchdog: a stopped E clock parks the sequencer until reset
  assign to_hit = TIMEOUT_CLKS < 0;
`endif
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = accept ? SYNC : IDLE;
      SYNC:    state_d = !bus.cia_space_i ? IDLE : e_fall ? SETUP : SYNC;
      SETUP:   state_d = e_rise ? STROBE : SETUP;
      STROBE:  state_d = e_fall ? HOLD : STROBE;
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (to_hit) state_d = IDLE;
  end
  // outputs are registered from the next state so they change with the state itself
  always_comb begin
    a_d     = accept ? bus.a_i : a_q;
    rnw_d   = accept ? bus.rnw_i : rnw_q;
    sel     = (state_d == SETUP) | (state_d == STROBE) | (state_d == HOLD);
    cs0_d   = ~(sel & ~a_d[0]);
    cs1_d   = ~(sel & ~a_d[1]);
    buf_d   = ~sel;
    done_d  = state_d == HOLD;
    dl_d    = done_d & rnw_d;
    tea_d   = to_hit;
    busy_d  = state_d != IDLE;
    armed_d = ~bus.cia_space_i | (armed_q & ~(done_d | to_hit));
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync_q  <= '0;
      e_d_q   <= 1'b0;
      state_q <= IDLE;
      armed_q <= 1'b1;
      a_q     <= 2'b11;
      rnw_q   <= 1'b0;
      cs0_q   <= 1'b1;
      cs1_q   <= 1'b1;
      buf_q   <= 1'b1;
      dl_q    <= 1'b0;
      done_q  <= 1'b0;
      tea_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[E_SYNC_STAGES-2:0], bus.clkcia_i};
      e_d_q   <= e_s;
      state_q <= state_d;
      armed_q <= armed_d;
      a_q     <= a_d;
      rnw_q   <= rnw_d;
      cs0_q   <= cs0_d;
      cs1_q   <= cs1_d;
      buf_q   <= buf_d;
      dl_q    <= dl_d;
      done_q  <= done_d;
      tea_q   <= tea_d;
      busy_q  <= busy_d;
    end
  assign bus.nciacs0_o    = cs0_q;
  assign bus.nciacs1_o    = cs1_q;
  assign bus.nciabufen_o  = buf_q;
  assign bus.cia_dlatch_o = dl_q;
  assign bus.cia_done_o   = done_q;
  assign bus.cia_tea_o    = tea_q;
  assign bus.cia_busy_o   = busy_q;
endmodule
